// File: rtl/hbm_scrub_engine_if.sv
// Memory-side port of the HBM scrub engine: req/ack handshake with read data and ECC status.
// master: scrub engine. slave: HBM channel controller (or a model of it).
interface hbm_scrub_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ecc_ce;
  logic              mem_ecc_ue;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata,
    input  mem_ecc_ce,
    input  mem_ecc_ue
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata,
    output mem_ecc_ce,
    output mem_ecc_ue
  );

endinterface

// File: rtl/hbm_scrub_engine.sv
// HBM scrub engine: services demand scrubs from the SEU healer and runs a paced patrol scrub.
// Each scrub reads a word; correctable data is written back, uncorrectable addresses are reported.
// Optional ack watchdog enabled by defining HBM_SCRUB_WATCHDOG_EN (ACK_TIMEOUT cycles).
module hbm_scrub_engine #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned PATROL_INTERVAL = 1024,
  parameter int unsigned ACK_TIMEOUT     = 256
) (
  input  logic               clk_2gt,
  input  logic               rst_n,
  input  logic               scrub_trigger,
  input  logic [ADDR_W-1:0]  err_addr,
  input  logic               patrol_en,
  hbm_scrub_engine_if.master mem_bus,
  output logic               scrub_busy,
  output logic               scrub_done,
  output logic [15:0]        ce_count,
  output logic               ue_flag,
  output logic [ADDR_W-1:0]  ue_addr,
  input  logic               ue_clear,
  output logic               req_overflow,
  output logic [ADDR_W-1:0]  patrol_addr,
  output logic               patrol_wrap,
  output logic               scrub_timeout
);

  if (PATROL_INTERVAL < 2 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("hbm_scrub_engine: PATROL_INTERVAL must be >= 2 and ACK_TIMEOUT >= 1");
  end

  localparam int unsigned IntW = $clog2(PATROL_INTERVAL);
  localparam logic [IntW-1:0] IntLast = IntW'(PATROL_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pend_vld_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [IntW-1:0]   int_q;
  logic              is_patrol_q;
  logic [15:0]       ce_count_q;
  logic              ue_flag_q;
  logic [ADDR_W-1:0] ue_addr_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] patrol_addr_q;
  logic              wrap_q;
  logic              done_q;
  logic              wd_expire;

`ifdef HBM_SCRUB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(ACK_TIMEOUT - 1);

  logic [WdW-1:0] wd_q;
  logic           timeout_q;

  assign wd_expire = (wd_q == WdLast);

  // Count cycles the current request has waited for ack; restarts for each new request.
  always_ff @(posedge clk_2gt or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StIdle || mem_bus.mem_ack) begin
        wd_q <= '0;
      end else if (req_q) begin
        wd_q <= wd_q + 1'b1;
      end
      if ((state_q == StRd || state_q == StWr) && !mem_bus.mem_ack && wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign scrub_timeout = timeout_q;
`else
  assign wd_expire     = 1'b0;
  assign scrub_timeout = 1'b0;
`endif

  // Scrub FSM with registered memory-port and status outputs.
  always_ff @(posedge clk_2gt or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pend_vld_q    <= 1'b0;
      pend_addr_q   <= '0;
      is_patrol_q   <= 1'b0;
      ce_count_q    <= '0;
      ue_flag_q     <= 1'b0;
      ue_addr_q     <= '0;
      overflow_q    <= 1'b0;
      patrol_addr_q <= '0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      // A UE detected below on the same edge overrides this clear.
      if (ue_clear) begin
        ue_flag_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (pend_vld_q) begin
            state_q     <= StRd;
            req_q       <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= pend_addr_q;
            is_patrol_q <= 1'b0;
            // A trigger on this edge refills the slot just freed.
            if (scrub_trigger) begin
              pend_addr_q <= err_addr;
            end else begin
              pend_vld_q <= 1'b0;
            end
          end else if (scrub_trigger) begin
            state_q     <= StRd;
            req_q       <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= err_addr;
            is_patrol_q <= 1'b0;
          end else if (patrol_en && int_q == IntLast) begin
            state_q     <= StRd;
            req_q       <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= patrol_addr_q;
            is_patrol_q <= 1'b1;
          end
        end
        StRd: begin
          if (mem_bus.mem_ack) begin
            if (mem_bus.mem_ecc_ue) begin
              req_q     <= 1'b0;
              ue_flag_q <= 1'b1;
              ue_addr_q <= addr_q;
              state_q   <= StDone;
            end else if (mem_bus.mem_ecc_ce) begin
              if (ce_count_q != 16'hFFFF) begin
                ce_count_q <= ce_count_q + 16'd1;
              end
              we_q    <= 1'b1;
              wdata_q <= mem_bus.mem_rdata;
              state_q <= StWr;
            end else begin
              req_q   <= 1'b0;
              state_q <= StDone;
            end
          end else if (wd_expire) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= StDone;
          end
        end
        StWr: begin
          if (mem_bus.mem_ack || wd_expire) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (is_patrol_q) begin
            patrol_addr_q <= patrol_addr_q + 1'b1;
            wrap_q        <= &patrol_addr_q;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Demand arriving mid-scrub goes to the single pending slot, or is dropped.
      if (state_q != StIdle && scrub_trigger) begin
        if (!pend_vld_q) begin
          pend_vld_q  <= 1'b1;
          pend_addr_q <= err_addr;
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Patrol pacing counter: advances only while idle with no demand work waiting.
  always_ff @(posedge clk_2gt or negedge rst_n) begin
    if (!rst_n) begin
      int_q <= '0;
    end else if (!patrol_en) begin
      int_q <= '0;
    end else if (state_q == StIdle && !pend_vld_q && !scrub_trigger) begin
      if (int_q == IntLast) begin
        int_q <= '0;
      end else begin
        int_q <= int_q + 1'b1;
      end
    end
  end

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;

  assign scrub_busy   = (state_q != StIdle);
  assign scrub_done   = done_q;
  assign ce_count     = ce_count_q;
  assign ue_flag      = ue_flag_q;
  assign ue_addr      = ue_addr_q;
  assign req_overflow = overflow_q;
  assign patrol_addr  = patrol_addr_q;
  assign patrol_wrap  = wrap_q;

endmodule

// File: tb/tb_hbm_scrub_engine.sv
// Self-checking bench for hbm_scrub_engine: a 16-bit demand instance and a 2-bit patrol instance.
module tb_hbm_scrub_engine;

  logic clk_2gt = 1'b0;
  always #5 clk_2gt = ~clk_2gt;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk_2gt) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Demand instance
  hbm_scrub_engine_if #(.ADDR_W(16), .DATA_W(64)) bus_a ();
  logic        a_trig, a_patrol_en, a_ue_clear;
  logic [15:0] a_err_addr;
  logic        a_busy, a_done, a_ue_flag, a_ovf, a_wrap, a_timeout;
  logic [15:0] a_ce_count, a_ue_addr, a_patrol_addr;

  hbm_scrub_engine #(.ADDR_W(16), .DATA_W(64), .PATROL_INTERVAL(1024), .ACK_TIMEOUT(8)) dut_a (
    .clk_2gt(clk_2gt), .rst_n(rst_n), .scrub_trigger(a_trig), .err_addr(a_err_addr),
    .patrol_en(a_patrol_en), .mem_bus(bus_a), .scrub_busy(a_busy), .scrub_done(a_done),
    .ce_count(a_ce_count), .ue_flag(a_ue_flag), .ue_addr(a_ue_addr), .ue_clear(a_ue_clear),
    .req_overflow(a_ovf), .patrol_addr(a_patrol_addr), .patrol_wrap(a_wrap),
    .scrub_timeout(a_timeout)
  );

  // Patrol instance
  hbm_scrub_engine_if #(.ADDR_W(2), .DATA_W(8)) bus_p ();
  logic        p_trig, p_en, p_ue_clear;
  logic [1:0]  p_err_addr;
  logic        p_busy, p_done, p_ue_flag, p_ovf, p_wrap, p_timeout;
  logic [15:0] p_ce_count;
  logic [1:0]  p_ue_addr, p_patrol_addr;

  hbm_scrub_engine #(.ADDR_W(2), .DATA_W(8), .PATROL_INTERVAL(4), .ACK_TIMEOUT(8)) dut_p (
    .clk_2gt(clk_2gt), .rst_n(rst_n), .scrub_trigger(p_trig), .err_addr(p_err_addr),
    .patrol_en(p_en), .mem_bus(bus_p), .scrub_busy(p_busy), .scrub_done(p_done),
    .ce_count(p_ce_count), .ue_flag(p_ue_flag), .ue_addr(p_ue_addr), .ue_clear(p_ue_clear),
    .req_overflow(p_ovf), .patrol_addr(p_patrol_addr), .patrol_wrap(p_wrap),
    .scrub_timeout(p_timeout)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
  } txn_t;

  txn_t       sb_a[$];
  logic [1:0] sb_p[$];

  logic        ack_en;
  logic [63:0] resp_rdata;
  logic        resp_ce, resp_ue;
  int          p_last;
  logic        p_space;

  // Memory model A: acks each request in the cycle it appears, checks it against the scoreboard.
  initial begin : resp_a
    txn_t e;
    bus_a.mem_ack = 1'b0; bus_a.mem_rdata = '0; bus_a.mem_ecc_ce = 1'b0; bus_a.mem_ecc_ue = 1'b0;
    forever begin
      @(negedge clk_2gt); #2;
      if (bus_a.mem_req && ack_en && rst_n) begin
        bus_a.mem_ack    = 1'b1;
        bus_a.mem_rdata  = resp_rdata;
        bus_a.mem_ecc_ce = resp_ce && !bus_a.mem_we;
        bus_a.mem_ecc_ue = resp_ue && !bus_a.mem_we;
        if (sb_a.size() == 0) begin
          chk("a_txn_expected", 64'(sb_a.size() != 0), 64'd1);
        end else begin
          e = sb_a.pop_front();
          chk("a_txn_we", 64'(bus_a.mem_we), 64'(e.we));
          chk("a_txn_addr", 64'(bus_a.mem_addr), 64'(e.addr));
          if (e.we) chk("a_txn_wdata", bus_a.mem_wdata, e.wdata);
        end
      end else begin
        bus_a.mem_ack    = 1'b0;
        bus_a.mem_ecc_ce = 1'b0;
        bus_a.mem_ecc_ue = 1'b0;
      end
    end
  end

  // Memory model P: always acks clean; checks order and patrol spacing.
  initial begin : resp_p
    bus_p.mem_ack = 1'b0; bus_p.mem_rdata = '0; bus_p.mem_ecc_ce = 1'b0; bus_p.mem_ecc_ue = 1'b0;
    forever begin
      @(negedge clk_2gt); #2;
      if (bus_p.mem_req && rst_n) begin
        bus_p.mem_ack = 1'b1;
        if (sb_p.size() == 0) begin
          chk("p_txn_expected", 64'(sb_p.size() != 0), 64'd1);
        end else begin
          chk("p_txn_we", 64'(bus_p.mem_we), 64'd0);
          chk("p_txn_addr", 64'(bus_p.mem_addr), 64'(sb_p.pop_front()));
        end
        if (p_space && p_last >= 0) chk("p_read_spacing", 64'(cyc - p_last), 64'd6);
        p_last = cyc;
      end else begin
        bus_p.mem_ack = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [63:0] rdata;
    logic        ce;
    logic        ue;
    logic        clr_at_ack;
    int          exp_lat;
    logic [15:0] exp_ce;
    logic        exp_ue_flag;
    logic [15:0] exp_ue_addr;
  } vec_t;

  initial begin : main
    vec_t vecs[6];
    txn_t t;
    int   lat, dones, cnt;
    logic seen;

    rst_n = 1'b0;
    a_trig = 1'b0; a_err_addr = '0; a_patrol_en = 1'b0; a_ue_clear = 1'b0;
    p_trig = 1'b0; p_err_addr = '0; p_en = 1'b0; p_ue_clear = 1'b0;
    ack_en = 1'b1; resp_rdata = '0; resp_ce = 1'b0; resp_ue = 1'b0;
    p_last = -1; p_space = 1'b0;

    repeat (3) @(negedge clk_2gt);
    chk("rst_a_req", 64'(bus_a.mem_req), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_done", 64'(a_done), 64'd0);
    chk("rst_a_ce_count", 64'(a_ce_count), 64'd0);
    chk("rst_a_ue_flag", 64'(a_ue_flag), 64'd0);
    chk("rst_a_ovf", 64'(a_ovf), 64'd0);
    chk("rst_a_timeout", 64'(a_timeout), 64'd0);
    chk("rst_p_patrol_addr", 64'(p_patrol_addr), 64'd0);
    chk("rst_p_req", 64'(bus_p.mem_req), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_2gt);

    //          addr      rdata                   ce    ue    clr   lat ce     uef   ue_addr
    vecs[0] = '{16'h1234, 64'h0000_0000_0000_1111, 1'b0, 1'b0, 1'b0, 3, 16'd0, 1'b0, 16'h0000};
    vecs[1] = '{16'h1234, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 1'b0, 4, 16'd1, 1'b0, 16'h0000};
    vecs[2] = '{16'h00FF, 64'h5555_0000_AAAA_0000, 1'b0, 1'b1, 1'b1, 3, 16'd1, 1'b1, 16'h00FF};
    vecs[3] = '{16'h0777, 64'h7777_7777_7777_7777, 1'b1, 1'b1, 1'b0, 3, 16'd1, 1'b1, 16'h0777};
    vecs[4] = '{16'hABCD, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 4, 16'd2, 1'b1, 16'h0777};
    vecs[5] = '{16'hFFFF, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 1'b0, 3, 16'd2, 1'b1, 16'h0777};

    for (int i = 0; i < 6; i++) begin
      resp_rdata = vecs[i].rdata; resp_ce = vecs[i].ce; resp_ue = vecs[i].ue;
      t = '{1'b0, vecs[i].addr, 64'd0};
      sb_a.push_back(t);
      if (vecs[i].ce && !vecs[i].ue) begin
        t = '{1'b1, vecs[i].addr, vecs[i].rdata};
        sb_a.push_back(t);
      end
      a_trig = 1'b1; a_err_addr = vecs[i].addr;
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(negedge clk_2gt);
        a_trig = 1'b0;
        a_ue_clear = (c == 1) && vecs[i].clr_at_ack;
        if (a_done) begin seen = 1'b1; lat = c; end
      end
      a_ue_clear = 1'b0;
      chk($sformatf("v%0d_done_seen", i), 64'(seen), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_ce_count", i), 64'(a_ce_count), 64'(vecs[i].exp_ce));
      chk($sformatf("v%0d_ue_flag", i), 64'(a_ue_flag), 64'(vecs[i].exp_ue_flag));
      chk($sformatf("v%0d_ue_addr", i), 64'(a_ue_addr), 64'(vecs[i].exp_ue_addr));
      chk($sformatf("v%0d_sb_drained", i), 64'(sb_a.size()), 64'd0);
      @(negedge clk_2gt);
    end

    // A lone clear drops the flag but keeps the last UE address.
    a_ue_clear = 1'b1;
    @(negedge clk_2gt);
    a_ue_clear = 1'b0;
    chk("ue_clear_flag", 64'(a_ue_flag), 64'd0);
    chk("ue_clear_addr_kept", 64'(a_ue_addr), 64'h0777);

    // Busy queuing: 0x10 runs, 0x20 waits in the slot, 0x30 overflows.
    ack_en = 1'b0; resp_ce = 1'b0; resp_ue = 1'b0;
    t = '{1'b0, 16'h0010, 64'd0}; sb_a.push_back(t);
    t = '{1'b0, 16'h0020, 64'd0}; sb_a.push_back(t);
    a_trig = 1'b1; a_err_addr = 16'h0010;
    @(negedge clk_2gt); a_err_addr = 16'h0020;
    @(negedge clk_2gt); a_err_addr = 16'h0030;
    @(negedge clk_2gt); a_trig = 1'b0;
    chk("q_busy", 64'(a_busy), 64'd1);
    chk("q_req_held", 64'(bus_a.mem_req), 64'd1);
    chk("q_addr_held", 64'(bus_a.mem_addr), 64'h0010);
    chk("q_overflow", 64'(a_ovf), 64'd1);
    ack_en = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_2gt);
      if (a_done) dones++;
    end
    chk("q_done_count", 64'(dones), 64'd2);
    chk("q_sb_drained", 64'(sb_a.size()), 64'd0);
    chk("q_idle_after", 64'(a_busy), 64'd0);

    // Patrol: reads 0,1,2,3,0 six cycles apart, wrap after address 3.
    p_last = -1; p_space = 1'b1;
    sb_p.push_back(2'd0); sb_p.push_back(2'd1); sb_p.push_back(2'd2);
    sb_p.push_back(2'd3); sb_p.push_back(2'd0);
    p_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk_2gt);
      if (p_wrap) seen = 1'b1;
    end
    chk("p_wrap_seen", 64'(seen), 64'd1);
    chk("p_wrap_addr", 64'(p_patrol_addr), 64'd0);
    chk("p_wrap_sb_left", 64'(sb_p.size()), 64'd1);
    @(negedge clk_2gt);
    chk("p_wrap_pulse", 64'(p_wrap), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_2gt);
      if (sb_p.size() == 0) seen = 1'b1;
    end
    chk("p_second_round", 64'(seen), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_2gt);
      if (p_done) seen = 1'b1;
    end
    chk("p_done_seen", 64'(seen), 64'd1);
    // Demand lands on the edge the interval counter reaches its last count.
    p_space = 1'b0;
    sb_p.push_back(2'd3); sb_p.push_back(2'd1);
    repeat (3) @(negedge clk_2gt);
    p_trig = 1'b1; p_err_addr = 2'd3;
    @(negedge clk_2gt);
    p_trig = 1'b0;
    dones = 0;
    for (int c = 0; c < 30 && dones < 2; c++) begin
      @(negedge clk_2gt);
      if (p_done) dones++;
    end
    chk("p_preempt_dones", 64'(dones), 64'd2);
    chk("p_preempt_sb", 64'(sb_p.size()), 64'd0);
    chk("p_addr_after", 64'(p_patrol_addr), 64'd2);
    p_en = 1'b0;

`ifdef HBM_SCRUB_WATCHDOG_EN
    ack_en = 1'b0;
    a_trig = 1'b1; a_err_addr = 16'h0B0B;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk_2gt);
      a_trig = 1'b0;
      if (bus_a.mem_req) cnt++;
      else if (cnt > 0) seen = 1'b1;
    end
    chk("wd_req_cycles", 64'(cnt), 64'd8);
    chk("wd_timeout", 64'(a_timeout), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (a_done) seen = 1'b1;
      else @(negedge clk_2gt);
    end
    chk("wd_done", 64'(seen), 64'd1);
    chk("wd_ce_kept", 64'(a_ce_count), 64'd2);
    chk("wd_ue_kept", 64'(a_ue_addr), 64'h0777);
    @(negedge clk_2gt);
`endif

    // Stall a read, then reset asynchronously mid-transaction.
    ack_en = 1'b0;
    a_trig = 1'b1; a_err_addr = 16'h0BAD;
    @(negedge clk_2gt);
    a_trig = 1'b0;
`ifdef HBM_SCRUB_WATCHDOG_EN
    repeat (2) @(negedge clk_2gt);
`else
    repeat (20) @(negedge clk_2gt);
    chk("stall_no_timeout", 64'(a_timeout), 64'd0);
`endif
    chk("stall_req", 64'(bus_a.mem_req), 64'd1);
    chk("stall_addr", 64'(bus_a.mem_addr), 64'h0BAD);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 64'(bus_a.mem_req), 64'd0);
    chk("async_rst_busy", 64'(a_busy), 64'd0);
    chk("async_rst_ce", 64'(a_ce_count), 64'd0);
    chk("async_rst_ovf", 64'(a_ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
